// File: rtl/microwire_pkg.sv
// microwire_pkg: shared encodings for the Microwire EEPROM controller.
// Holds the host opcode enum, controller FSM state enum and on-wire opcode bits.
// No logic; imported by microwire_ctrl and microwire_sk_gen.
package microwire_pkg;

    // Host-side command opcodes; values 5..7 are illegal.
    typedef enum logic [2:0] {
        OP_READ  = 3'd0,
        OP_WRITE = 3'd1,
        OP_ERASE = 3'd2,
        OP_EWEN  = 3'd3,
        OP_EWDS  = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_OUT,
        ST_SHIFT_IN,
        ST_CS_GAP,
        ST_POLL,
        ST_RESP
    } state_e;

    // Two-bit opcode field sent on the wire after the start bit.
    localparam logic [1:0] SER_READ  = 2'b10;
    localparam logic [1:0] SER_WRITE = 2'b01;
    localparam logic [1:0] SER_ERASE = 2'b11;
    localparam logic [1:0] SER_EWX   = 2'b00;

    // EWEN/EWDS are told apart by the two address MSBs.
    localparam logic [1:0] EWEN_ADDR_HI = 2'b11;
    localparam logic [1:0] EWDS_ADDR_HI = 2'b00;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/microwire_sk_gen.sv
// microwire_sk_gen: SK phase generator; each SK half-period lasts SK_DIV clk cycles.
// Latency: strobes are combinational from the phase counter, valid in the last cycle of a half-period.
// Backpressure: none; en low or clr high forces phase 0 (SK low) with the counter cleared.
// Ports: clk/rst_n; en, clr from the FSM; sk_lvl = current phase (1 = high half);
//        sk_rise = end of low half, sk_fall = end of high half.
module microwire_sk_gen
    import microwire_pkg::*;
#(
    parameter int SK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic sk_lvl,
    output logic sk_rise,
    output logic sk_fall
);
    localparam int DIV_W = (SK_DIV > 2) ? $clog2(SK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             half_end;

    assign half_end = (cnt_q == DIV_LAST);

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en || clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (half_end) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign sk_lvl  = phase_q;
    assign sk_rise = en && half_end && !phase_q;
    assign sk_fall = en && half_end && phase_q;

endmodule

// File: rtl/microwire_ctrl.sv
// microwire_ctrl: host command interface to a 93C46-style Microwire serial EEPROM.
// Latency: one command in flight; 3+ADDR_W (+DATA_W) SK periods of frame, plus read or ready-poll time.
// Backpressure: cmd_ready only in IDLE; rsp_valid is a one-cycle pulse the host must take.
// Ports: cmd_* host request (op/addr/wdata captured at acceptance); rsp_* completion
//        (rdata held until the next READ completes, err = illegal op or poll timeout);
//        ee_cs/ee_sk/ee_di/ee_do EEPROM pins.
module microwire_ctrl
    import microwire_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int SK_DIV   = 4,
    parameter int POLL_MAX = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ee_cs,
    output logic              ee_sk,
    output logic              ee_di,
    input  logic              ee_do
);
    localparam int FRAME_W = 3 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int POLL_W  = $clog2(POLL_MAX + 1);

    localparam logic [CNT_W-1:0]  LEN_SHORT = CNT_W'(3 + ADDR_W);
    localparam logic [CNT_W-1:0]  LEN_WRITE = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [POLL_W-1:0]    poll_cnt_q, poll_cnt_d;
    logic                 di_q, di_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic                 sk_en, sk_clr, sk_lvl, sk_rise, sk_fall;
    logic [1:0]           ser_op;
    logic [ADDR_W-1:0]    ser_addr;
    logic [DATA_W-1:0]    ser_data;
    logic [FRAME_W-1:0]   frame_init;
    logic [CNT_W-1:0]     frame_len;

    // Outgoing frame, left-aligned so it always shifts out of the MSB.
    always_comb begin
        ser_op   = SER_EWX;
        ser_addr = cmd_addr;
        ser_data = '0;
        case (op_e'(cmd_op))
            OP_READ:  ser_op = SER_READ;
            OP_WRITE: begin
                ser_op   = SER_WRITE;
                ser_data = cmd_wdata;
            end
            OP_ERASE: ser_op = SER_ERASE;
            OP_EWEN: begin
                ser_addr                 = '0;
                ser_addr[ADDR_W-1 -: 2]  = EWEN_ADDR_HI;
            end
            OP_EWDS: begin
                ser_addr                 = '0;
                ser_addr[ADDR_W-1 -: 2]  = EWDS_ADDR_HI;
            end
            default: ;
        endcase
    end

    assign frame_init = {1'b1, ser_op, ser_addr, ser_data};
    assign frame_len  = (op_q == OP_WRITE) ? LEN_WRITE : LEN_SHORT;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        poll_cnt_d = poll_cnt_q;
        di_d       = di_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    bit_cnt_d  = '0;
                    poll_cnt_d = '0;
                    if (op_legal(cmd_op)) begin
                        op_d    = op_e'(cmd_op);
                        frame_d = frame_init;
                        err_d   = 1'b0;
                        state_d = ST_SETUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            // CS high, SK low for one half-period; the start bit is presented here.
            ST_SETUP: begin
                if (sk_rise) begin
                    di_d      = frame_q[FRAME_W-1];
                    frame_d   = frame_q << 1;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = ST_SHIFT_OUT;
                end
            end
            // Bits change only at the end of the high half (SK falling).
            ST_SHIFT_OUT: begin
                if (sk_fall) begin
                    if (bit_cnt_q == frame_len) begin
                        di_d      = 1'b0;
                        bit_cnt_d = '0;
                        case (op_q)
                            OP_READ:           state_d = ST_SHIFT_IN;
                            OP_WRITE, OP_ERASE: state_d = ST_CS_GAP;
                            default:           state_d = ST_RESP;
                        endcase
                    end else begin
                        di_d      = frame_q[FRAME_W-1];
                        frame_d   = frame_q << 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            // The frame register is idle now, so it doubles as the read shifter.
            ST_SHIFT_IN: begin
                if (sk_fall) begin
                    frame_d = {frame_q[FRAME_W-2:0], ee_do};
                    if (bit_cnt_q == RD_LAST) begin
                        rdata_d = {frame_q[DATA_W-2:0], ee_do};
                        state_d = ST_RESP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CS_GAP: begin
                if (sk_fall) begin
                    state_d = ST_POLL;
                end
            end
            // EEPROM drives DO high once its internal program/erase cycle is done.
            ST_POLL: begin
                if (sk_fall) begin
                    if (ee_do) begin
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        poll_cnt_d = poll_cnt_q + POLL_W'(1);
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            poll_cnt_q <= '0;
            di_q       <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            di_q       <= di_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Restarting the SK phase on every state change keeps SK low at each state entry.
    assign sk_en  = (state_q != ST_IDLE) && (state_q != ST_RESP);
    assign sk_clr = (state_d != state_q);

    microwire_sk_gen #(
        .SK_DIV (SK_DIV)
    ) u_sk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (sk_en),
        .clr     (sk_clr),
        .sk_lvl  (sk_lvl),
        .sk_rise (sk_rise),
        .sk_fall (sk_fall)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign ee_cs     = (state_q == ST_SETUP) || (state_q == ST_SHIFT_OUT) ||
                       (state_q == ST_SHIFT_IN) || (state_q == ST_POLL);
    // SK only toggles while bits are moving; SETUP, CS_GAP and POLL keep it low.
    assign ee_sk     = sk_lvl && ((state_q == ST_SHIFT_OUT) || (state_q == ST_SHIFT_IN));
    assign ee_di     = di_q;

endmodule

// File: tb/tb_microwire_ctrl.sv
// tb_microwire_ctrl: directed bench for microwire_ctrl with a small behavioural EEPROM.
// Latency: n/a (bench).
// Backpressure: n/a (bench); every wait on the DUT is bounded.
module tb_microwire_ctrl;
    localparam int SK_DIV = 4;
    localparam int PER    = 2 * SK_DIV;
    localparam int LIMIT  = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_valid8 = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [5:0]  cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;

    logic        cmd_ready, rsp_valid, rsp_err, ee_cs, ee_sk, ee_di, ee_do;
    logic [15:0] rsp_rdata;
    logic        cmd_ready8, rsp_valid8, rsp_err8, ee_cs8, ee_sk8, ee_di8;
    logic [15:0] rsp_rdata8;
    logic        ee_do8 = 1'b0;

    always #5 clk = ~clk;

    microwire_ctrl #(.ADDR_W(6), .DATA_W(16), .SK_DIV(SK_DIV), .POLL_MAX(64)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ee_cs(ee_cs), .ee_sk(ee_sk), .ee_di(ee_di), .ee_do(ee_do)
    );

    microwire_ctrl #(.ADDR_W(6), .DATA_W(16), .SK_DIV(SK_DIV), .POLL_MAX(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid8), .rsp_rdata(rsp_rdata8), .rsp_err(rsp_err8),
        .ee_cs(ee_cs8), .ee_sk(ee_sk8), .ee_di(ee_di8), .ee_do(ee_do8)
    );

    // EEPROM model: capture DI on SK rise; during a READ drive data bits after the 9-bit header.
    int          cap_n = 0, cap_base = 0;
    logic [63:0] cap = '0;
    logic        rd_mode = 1'b0, rd_bit = 1'b0, poll_do = 1'b0;
    logic [15:0] rd_word = '0;
    assign ee_do = rd_mode ? rd_bit : poll_do;

    always @(posedge ee_sk) begin
        if (ee_cs) begin
            int k;
            k = cap_n - cap_base;
            cap = {cap[62:0], ee_di};
            cap_n = cap_n + 1;
            if (k >= 9 && k < 25) rd_bit = rd_word[15 - (k - 9)];
        end
    end

    int rv_cnt = 0, cs_hi_cnt = 0;
    always @(posedge clk) begin
        if (rsp_valid) rv_cnt = rv_cnt + 1;
        if (ee_cs) cs_hi_cnt = cs_hi_cnt + 1;
    end

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present a command for one cycle, then scramble the fields to prove they were captured.
    task automatic send(input bit to8, input logic [2:0] op, input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        cmd_op = op; cmd_addr = a; cmd_wdata = d;
        if (to8) cmd_valid8 = 1'b1; else cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_valid8 = 1'b0;
        cmd_op = 3'd7; cmd_addr = '1; cmd_wdata = 16'hFFFF;
    endtask

    task automatic wait_rsp(input string tag);
        bit seen;
        int cyc;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < LIMIT) begin
            @(negedge clk); cyc++;
            if (rsp_valid) seen = 1'b1;
        end
        chk({tag, "_rsp_seen"}, seen, 1);
        @(negedge clk);
        chk({tag, "_rsp_pulse"}, rsp_valid, 0);
    endtask

    task automatic wait_cs(input bit use8, input logic lvl, input string tag, output int cyc);
        cyc = 0;
        while (((use8 ? ee_cs8 : ee_cs) !== lvl) && cyc < LIMIT) begin
            @(negedge clk); cyc++;
        end
        chk({tag, "_seen"}, (use8 ? ee_cs8 : ee_cs) === lvl, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, gap, rv0, cs0;
        bit got;

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("rst_cs", ee_cs, 0);
        chk("rst_sk", ee_sk, 0);
        chk("rst_di", ee_di, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_rdata", rsp_rdata, 16'h0000);
        chk("rst_p8_sk", ee_sk8, 0);
        chk("rst_p8_di", ee_di8, 0);
        chk("rst_p8_rdata", rsp_rdata8, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);

        // EWEN: 1,00,110000 then straight to response.
        cap_base = cap_n;
        send(1'b0, 3'd3, 6'h00, 16'h0000);
        chk("ewen_ready_busy", cmd_ready, 0);
        wait_rsp("ewen");
        chk("ewen_nbits", cap_n - cap_base, 9);
        chk("ewen_frame", cap[8:0], 9'b1_00_110000);
        chk("ewen_err", rsp_err, 0);

        // READ 0x3F returning 0x1234: 9 header + 16 data SK periods.
        cap_base = cap_n; rd_word = 16'h1234; rd_mode = 1'b1;
        send(1'b0, 3'd0, 6'h3F, 16'h0000);
        wait_rsp("rd");
        chk("rd_nbits", cap_n - cap_base, 25);
        chk("rd_hdr", cap[24:16], 9'b1_10_111111);
        chk("rd_data", rsp_rdata, 16'h1234);
        chk("rd_err", rsp_err, 0);
        rd_mode = 1'b0;

        // WRITE 0x15 <- 0xA55A; ready after 20 busy polls.
        cap_base = cap_n; poll_do = 1'b0;
        send(1'b0, 3'd1, 6'h15, 16'hA55A);
        wait_cs(1'b0, 1'b0, "wr_cs_drop", c);
        wait_cs(1'b0, 1'b1, "wr_cs_rise", gap);
        chk("wr_gap", gap, PER);
        chk("wr_nbits", cap_n - cap_base, 25);
        chk("wr_frame", cap[24:0], 25'b1_01_010101_1010_0101_0101_1010);
        c = 0; got = 1'b0;
        while (!got && c < LIMIT) begin
            @(negedge clk); c++;
            if (c == 20 * PER) poll_do = 1'b1;
            if (rsp_valid) got = 1'b1;
        end
        chk("wr_rsp_seen", got, 1);
        chk("wr_poll_cyc", c, 21 * PER);
        chk("wr_err", rsp_err, 0);
        chk("wr_rdata_hold", rsp_rdata, 16'h1234);
        @(negedge clk);
        chk("wr_rsp_pulse", rsp_valid, 0);
        poll_do = 1'b0;

        // ERASE on the POLL_MAX=8 instance with DO stuck low: 8 samples then error.
        send(1'b1, 3'd2, 6'h01, 16'h0000);
        wait_cs(1'b1, 1'b0, "er_cs_drop", c);
        wait_cs(1'b1, 1'b1, "er_cs_rise", gap);
        chk("er_gap", gap, PER);
        c = 0; got = 1'b0;
        while (!got && c < LIMIT) begin
            @(negedge clk); c++;
            if (rsp_valid8) got = 1'b1;
        end
        chk("er_rsp_seen", got, 1);
        chk("er_poll_cyc", c, 8 * PER);
        chk("er_err", rsp_err8, 1);
        @(negedge clk);
        chk("er_ready", cmd_ready8, 1);

        // Illegal opcode 6: immediate error response, no pin activity.
        cs0 = cs_hi_cnt;
        send(1'b0, 3'd6, 6'h00, 16'h0000);
        chk("ill_valid", rsp_valid, 1);
        chk("ill_err", rsp_err, 1);
        repeat (3) @(negedge clk);
        chk("ill_pulse", rsp_valid, 0);
        chk("ill_no_cs", cs_hi_cnt - cs0, 0);

        // Reset during READ bit 10 aborts with no response.
        cap_base = cap_n; rd_word = 16'hBEEF; rd_mode = 1'b1;
        send(1'b0, 3'd0, 6'h2A, 16'h0000);
        c = 0;
        while ((cap_n - cap_base) < 10 && c < LIMIT) begin
            @(negedge clk); c++;
        end
        chk("ab_reach_bit10", cap_n - cap_base, 10);
        chk("ab_pre_sk", ee_sk, 1);
        rv0 = rv_cnt;
        rst_n = 1'b0;
        #1;
        chk("ab_cs", ee_cs, 0);
        chk("ab_sk", ee_sk, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ab_no_rsp", rv_cnt - rv0, 0);
        chk("ab_rdata", rsp_rdata, 16'h0000);
        chk("ab_ready", cmd_ready, 1);

        // Following READ completes normally.
        cap_base = cap_n; rd_word = 16'h5A3C;
        send(1'b0, 3'd0, 6'h2A, 16'h0000);
        wait_rsp("rd2");
        chk("rd2_nbits", cap_n - cap_base, 25);
        chk("rd2_hdr", cap[24:16], 9'b1_10_101010);
        chk("rd2_data", rsp_rdata, 16'h5A3C);
        chk("rd2_err", rsp_err, 0);
        rd_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/microwire_ctrl.md
MICROWIRE_CTRL -- requirements
Module: microwire_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, EEPROM address bits (93C46 x16 organisation).
REQ-002 SHALL have parameter DATA_W, default 16, EEPROM word width.
REQ-003 SHALL have parameter SK_DIV, default 4, clk cycles per SK half-period (minimum 2).
REQ-004 SHALL have parameter POLL_MAX, default 4096, SK periods allowed for write/erase ready polling.
REQ-005 SHALL have ports, clock and reset first:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command request
cmd_ready  out  1  controller accepts command
cmd_op  in  3  0 READ, 1 WRITE, 2 ERASE, 3 EWEN, 4 EWDS
cmd_addr  in  ADDR_W  word address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  illegal opcode or poll timeout, valid with rsp_valid
ee_cs  out  1  EEPROM chip select, active high
ee_sk  out  1  EEPROM serial clock
ee_di  out  1  serial data to EEPROM
ee_do  in  1  serial data from EEPROM

Function
REQ-006 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready SHALL be high only in IDLE.
REQ-007 SHALL capture cmd_op/addr/wdata at acceptance; later input changes SHALL have no effect.
REQ-008 SHALL use FSM states IDLE, SETUP, SHIFT_OUT, SHIFT_IN, CS_GAP, POLL, RESP.
REQ-009 Opcodes 5-7 SHALL go IDLE->RESP with rsp_err=1, no pin activity.
REQ-010 SETUP: ee_cs=1, ee_sk=0 for one SK half-period, then SHIFT_OUT.
REQ-011 SHIFT_OUT frame, MSB first: start bit 1, 2-bit opcode (READ 10, WRITE 01, ERASE 11, EWEN/EWDS 00), ADDR_W address bits (EWEN: 11 then zeros; EWDS: 00 then zeros), then DATA_W data bits for WRITE only.
REQ-012 ee_di SHALL change only at ee_sk falling transitions or in SETUP; each bit SHALL occupy one full SK period (low then high).
REQ-013 After frame: READ->SHIFT_IN; WRITE/ERASE->CS_GAP; EWEN/EWDS->RESP with ee_cs=0.
REQ-014 SHIFT_IN SHALL run DATA_W SK periods, sampling ee_do on each high->low ee_sk transition, MSB first, into rsp_rdata.
REQ-015 CS_GAP SHALL hold ee_cs=0, ee_sk=0 for one SK period, then raise ee_cs and enter POLL.
REQ-016 POLL SHALL sample ee_do once per SK period (ee_sk held 0); ee_do=1 ->RESP rsp_err=0; POLL_MAX samples without 1 ->RESP rsp_err=1.
REQ-017 RESP SHALL drop ee_cs, pulse rsp_valid for exactly one clk, return to IDLE; rsp_rdata SHALL hold until next READ completes.
REQ-018 ee_sk SHALL be 0 whenever ee_cs=0 and at every state entry.
REQ-019 Frame length SHALL be 3+ADDR_W (+DATA_W for WRITE); bit counter width ceil(log2(3+ADDR_W+DATA_W+1)).

Reset
REQ-020 rst_n low SHALL immediately force IDLE, ee_cs=0, ee_sk=0, ee_di=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counters 0; cmd_ready=1 after release.
REQ-021 Reset mid-transaction SHALL abort with no rsp_valid pulse.

Structure
REQ-022 Package microwire_pkg SHALL hold the op encoding enum, FSM state enum and serial opcode constants.
REQ-023 Sub-module microwire_sk_gen SHALL produce SK rise/fall strobes from SK_DIV, enabled by FSM, reset to phase 0 on enable.

Verification
REQ-024 EWEN: op=3 -> ee_di frame 1,00,110000 (9 SK periods), rsp_valid, rsp_err=0, no SHIFT_IN.
REQ-025 WRITE addr=0x15 data=0xA55A, model holds ee_do=0 for 20 polls then 1 -> frame 1,01,010101,1010010101011010; ee_cs low one SK period; rsp_err=0.
REQ-026 READ addr=0x3F, model returns 0x1234 -> 25 SK periods total, rsp_rdata=0x1234, rsp_err=0.
REQ-027 ERASE with ee_do stuck 0, POLL_MAX=8 -> 8 samples then rsp_err=1.
REQ-028 cmd_op=6 -> rsp_valid next RESP cycle with rsp_err=1, ee_cs never high.
REQ-029 rst_n asserted during READ bit 10 -> ee_cs/ee_sk 0 same cycle, no rsp_valid, next READ completes correctly.
